// File: rtl/frame_pkg.sv
// Shared definitions for the call/return frame sequencer: state encoding,
// frame record layout ({pc, tos}) and default parameter values.
package frame_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DEPTH_LOG2 = 4;

  // Frame record is {pc, tos}, pc in the upper half.
  localparam int FRAME_W = 2 * DEF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP_RD  = 2'd1,
    POP_OUT = 2'd2
  } state_t;

  function automatic int frame_width(input int addr_width);
    return 2 * addr_width;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame storage: one wide memory holding {pc, tos} records, single write
// port and a registered read port.
module frame_ram
  import frame_pkg::*;
#(
  parameter int AW      = DEF_DEPTH_LOG2,
  parameter int FRAME_W = frame_pkg::FRAME_W
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic               re,
  input  logic [AW-1:0]      rd_addr,
  output logic [FRAME_W-1:0] rd_data
);

  logic [FRAME_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= wr_data;
    if (re)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_return_ctrl.sv
// Call/return frame sequencer: pushes {pc, tos} on CALL, pops and returns
// them with the callee's value on RET. FRAME_DEPTH_HWM_EN adds a depth high-water mark.
module frame_return_ctrl
  import frame_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_req,
  input  logic [ADDR_WIDTH-1:0] call_pc,
  input  logic [ADDR_WIDTH-1:0] call_tos,
  output logic                  call_ack,
  input  logic                  ret_req,
  input  logic [DATA_WIDTH-1:0] ret_val,
  output logic                  ret_valid,
  output logic [ADDR_WIDTH-1:0] ret_pc,
  output logic [ADDR_WIDTH-1:0] ret_tos,
  output logic [DATA_WIDTH-1:0] ret_data,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DEPTH_LOG2:0]   depth_hwm
);

  localparam int FW = frame_width(ADDR_WIDTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   DEPTH_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   MAX_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] ptr, rd_addr;
  logic                  zero_frame;
  logic                  we, re, push, pop, ack_set, ovf_set, unf_set, ret_latch;
  logic [FW-1:0]         rd_frame_p1;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // RET has priority over CALL; RAM access only ever starts from IDLE.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    re        = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ack_set   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    ret_latch = 1'b0;
    case (state)
      IDLE: begin
        if (ret_req) begin
          ret_latch = 1'b1;
          re        = 1'b1;
          state_nxt = POP_RD;
          if (depth != '0)
            pop = 1'b1;
          else
            unf_set = 1'b1;
        end else if (call_req) begin
          ack_set = 1'b1;
          if (depth != MAX_DEPTH) begin
            we   = 1'b1;
            push = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      POP_RD:  state_nxt = POP_OUT;
      POP_OUT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_addr = ptr - PTR_ONE;
  assign busy    = (state != IDLE);

  frame_ram #(
    .AW      (DEPTH_LOG2),
    .FRAME_W (FW)
  ) u_frame_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (ptr),
    .wr_data ({call_pc, call_tos}),
    .re      (re),
    .rd_addr (rd_addr),
    .rd_data (rd_frame_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      depth      <= '0;
      call_ack   <= 1'b0;
      ret_valid  <= 1'b0;
      ret_pc     <= '0;
      ret_tos    <= '0;
      ret_data   <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      zero_frame <= 1'b0;
    end else begin
      call_ack  <= ack_set;
      ret_valid <= (state == POP_RD);
      if (push) begin
        ptr   <= ptr + PTR_ONE;
        depth <= depth + DEPTH_ONE;
      end else if (pop) begin
        ptr   <= ptr - PTR_ONE;
        depth <= depth - DEPTH_ONE;
      end
      if (ovf_set)
        overflow <= 1'b1;
      if (unf_set)
        underflow <= 1'b1;
      if (ret_latch) begin
        ret_data   <= ret_val;
        zero_frame <= unf_set;
      end
      // Frame read data is registered by now; publish it as POP_OUT begins.
      if (state == POP_RD) begin
        ret_pc  <= zero_frame ? '0 : rd_frame_p1[FW-1:ADDR_WIDTH];
        ret_tos <= zero_frame ? '0 : rd_frame_p1[ADDR_WIDTH-1:0];
      end
    end
  end

`ifdef FRAME_DEPTH_HWM_EN
  logic [DEPTH_LOG2:0] hwm;

  always_ff @(posedge clk) begin
    if (reset)
      hwm <= '0;
    else if (depth > hwm)
      hwm <= depth;
  end

  assign depth_hwm = hwm;
`else
  assign depth_hwm = '0;
`endif

endmodule

// File: tb/tb_frame_return_ctrl.sv
// Directed testbench for frame_return_ctrl: push/pop ordering, latency,
// overflow/underflow, RET-over-CALL priority and reset mid-pop.
module tb_frame_return_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        call_req;
  logic [11:0] call_pc;
  logic [11:0] call_tos;
  logic        call_ack;
  logic        ret_req;
  logic [7:0]  ret_val;
  logic        ret_valid;
  logic [11:0] ret_pc;
  logic [11:0] ret_tos;
  logic [7:0]  ret_data;
  logic        busy;
  logic [4:0]  depth;
  logic        overflow;
  logic        underflow;
  logic [4:0]  depth_hwm;

  int n_cmp = 0;
  int n_mis = 0;

  frame_return_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (12),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call_req),
    .call_pc   (call_pc),
    .call_tos  (call_tos),
    .call_ack  (call_ack),
    .ret_req   (ret_req),
    .ret_val   (ret_val),
    .ret_valid (ret_valid),
    .ret_pc    (ret_pc),
    .ret_tos   (ret_tos),
    .ret_data  (ret_data),
    .busy      (busy),
    .depth     (depth),
    .overflow  (overflow),
    .underflow (underflow),
    .depth_hwm (depth_hwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input string tag, input logic [11:0] pc, input logic [11:0] tos);
    int lat;
    call_pc  = pc;
    call_tos = tos;
    call_req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!call_ack && lat < 20);
    call_req = 1'b0;
    chk({tag, "_ack_lat"}, lat, 1);
  endtask

  task automatic do_ret(input string tag, input logic [7:0] val,
                        input logic [11:0] exp_pc, input logic [11:0] exp_tos);
    int   lat;
    logic busy_all;
    ret_val  = val;
    ret_req  = 1'b1;
    lat      = 0;
    busy_all = 1'b1;
    do begin
      tick();
      lat++;
      if (!busy) busy_all = 1'b0;
    end while (!ret_valid && lat < 20);
    ret_req = 1'b0;
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_busy"}, busy_all, 1'b1);
    chk({tag, "_pc"}, ret_pc, exp_pc);
    chk({tag, "_tos"}, ret_tos, exp_tos);
    chk({tag, "_data"}, ret_data, val);
    tick();
    chk({tag, "_pulse"}, ret_valid, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    call_req = 1'b0;
    call_pc  = '0;
    call_tos = '0;
    ret_req  = 1'b0;
    ret_val  = '0;
    repeat (3) tick();
    chk("rst_depth", depth, 0);
    chk("rst_ack", call_ack, 0);
    chk("rst_valid", ret_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_pc", ret_pc, 0);
    chk("rst_tos", ret_tos, 0);
    chk("rst_data", ret_data, 0);
    chk("rst_hwm", depth_hwm, 0);
    reset = 1'b0;
    tick();

    // Single CALL/RET round trip
    do_call("c1", 12'h123, 12'h045);
    chk("c1_depth", depth, 1);
    tick();
    chk("c1_ack_pulse", call_ack, 0);
    do_ret("r1", 8'hA5, 12'h123, 12'h045);
    chk("r1_depth", depth, 0);

    // LIFO order
    do_call("c3a", 12'h010, 12'h011);
    do_call("c3b", 12'h020, 12'h021);
    do_call("c3c", 12'h030, 12'h031);
    chk("c3_depth", depth, 3);
    do_ret("r3a", 8'h01, 12'h030, 12'h031);
    do_ret("r3b", 8'h02, 12'h020, 12'h021);
    do_ret("r3c", 8'h03, 12'h010, 12'h011);
    chk("r3_depth", depth, 0);

    // Fill to capacity, then overflow
    for (int i = 0; i < 16; i++)
      do_call("fill", 12'h100 + 12'(i), 12'h200 + 12'(i));
    chk("full_depth", depth, 16);
    chk("full_ovf", overflow, 0);
    do_call("c17", 12'hFFF, 12'hEEE);
    chk("c17_depth", depth, 16);
    chk("c17_ovf", overflow, 1);
    do_ret("r16", 8'h5A, 12'h10F, 12'h20F);
    chk("r16_depth", depth, 15);
    for (int i = 14; i >= 0; i--)
      do_ret("drain", 8'(i), 12'h100 + 12'(i), 12'h200 + 12'(i));
    chk("drain_depth", depth, 0);
    chk("drain_ovf_sticky", overflow, 1);

    // Underflow
    chk("pre_unf", underflow, 0);
    do_ret("runf", 8'h3C, 12'h000, 12'h000);
    chk("unf_flag", underflow, 1);
    chk("unf_depth", depth, 0);

    // Simultaneous CALL and RET: RET first, CALL acked afterwards
    do_call("s1", 12'h0A1, 12'h0B1);
    do_call("s2", 12'h0A2, 12'h0B2);
    chk("s_depth2", depth, 2);
    call_pc  = 12'h0A3;
    call_tos = 12'h0B3;
    ret_val  = 8'h77;
    call_req = 1'b1;
    ret_req  = 1'b1;
    tick();
    chk("s_noack", call_ack, 0);
    chk("s_busy", busy, 1);
    chk("s_depth1", depth, 1);
    tick();
    chk("s_valid", ret_valid, 1);
    chk("s_pc", ret_pc, 12'h0A2);
    chk("s_tos", ret_tos, 12'h0B2);
    ret_req = 1'b0;
    tick();
    chk("s_ack_wait", call_ack, 0);
    chk("s_depth_wait", depth, 1);
    tick();
    chk("s_ack", call_ack, 1);
    chk("s_depth_end", depth, 2);
    call_req = 1'b0;
    chk("s_pc_hold", ret_pc, 12'h0A2);
    do_ret("s_r", 8'h78, 12'h0A3, 12'h0B3);

    // Reset during POP_RD aborts the pop
    ret_val = 8'h99;
    ret_req = 1'b1;
    tick();
    chk("ab_busy", busy, 1);
    reset   = 1'b1;
    ret_req = 1'b0;
    tick();
    chk("ab_valid", ret_valid, 0);
    chk("ab_depth", depth, 0);
    chk("ab_busy0", busy, 0);
    chk("ab_ovf", overflow, 0);
    chk("ab_unf", underflow, 0);
    chk("ab_data", ret_data, 0);
    reset = 1'b0;
    tick();
    chk("ab_valid2", ret_valid, 0);

    // High-water mark
    for (int i = 0; i < 5; i++)
      do_call("hw", 12'h300 + 12'(i), 12'h400 + 12'(i));
    do_ret("hw_r1", 8'h11, 12'h304, 12'h404);
    do_ret("hw_r2", 8'h12, 12'h303, 12'h403);
    chk("hw_depth", depth, 3);
`ifdef FRAME_DEPTH_HWM_EN
    chk("hw_mark", depth_hwm, 5);
`else
    chk("hw_mark", depth_hwm, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/frame_return_ctrl.md
Name: frame_return_ctrl

Overview:
Call/return frame sequencer for the stack-machine core; the consumer end of the function frame storage.
- On CALL it pushes a frame {return PC, caller TOS}.
- On RET it pops the frame and hands the restored PC, TOS and the callee's return value back to the core through a valid pulse.
- Owns its frame RAM, depth counter and overflow/underflow flags.
- Sits between the control unit and the PC/TOS registers.

Parameters:
- DATA_WIDTH, 8, width of the return value.
- ADDR_WIDTH, 12, width of PC and TOS addresses.
- DEPTH_LOG2, 4, log2 of the maximum number of frames (16).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- call_req  input  1  push request; level, held until call_ack
- call_pc  input  ADDR_WIDTH  return address to save
- call_tos  input  ADDR_WIDTH  caller TOS to save
- call_ack  output  1  one-cycle pulse; CALL accepted
- ret_req  input  1  pop request; level, held until ret_valid
- ret_val  input  DATA_WIDTH  callee return value
- ret_valid  output  1  one-cycle pulse; ret_* outputs valid
- ret_pc  output  ADDR_WIDTH  restored PC, held until the next pop
- ret_tos  output  ADDR_WIDTH  restored TOS, held until the next pop
- ret_data  output  DATA_WIDTH  latched return value, held until the next pop
- busy  output  1  high while a pop is in flight
- depth  output  DEPTH_LOG2+1  current frame count
- overflow  output  1  sticky error flag
- underflow  output  1  sticky error flag
- depth_hwm  output  DEPTH_LOG2+1  high-water mark (see Optional Feature)

Behaviour:
- Reset: state IDLE. All outputs are 0: ptr, depth, call_ack, ret_valid, ret_pc, ret_tos, ret_data, busy, overflow, underflow, depth_hwm. RAM contents are not reset.
- FSM states: IDLE, POP_RD, POP_OUT.
- IDLE, call_req=1 (and ret_req=0):
  - If depth < 2^DEPTH_LOG2: write {call_pc, call_tos} at ptr, ptr++, depth++, call_ack=1 next cycle. State stays IDLE, so one push per cycle is possible.
  - If depth == 2^DEPTH_LOG2: no write, no pointer change, overflow<=1, call_ack still pulses.
- IDLE, ret_req=1:
  - ret_val is latched into ret_data.
  - If depth > 0: ptr--, depth--, RAM read address = ptr-1, go to POP_RD.
  - If depth == 0: underflow<=1, pointer unchanged, go to POP_RD with a zero-frame flag set.
- Simultaneous call_req and ret_req in IDLE: RET wins. CALL is not acked and stays pending.
- POP_RD: RAM read data registered (1-cycle synchronous read). Go to POP_OUT.
- POP_OUT:
  - ret_pc/ret_tos <= frame fields, or 0 if the zero-frame flag is set.
  - ret_valid=1 for exactly one cycle. Return to IDLE.
- Latency: ret_req sampled at edge N -> ret_valid high in cycle N+2. call_req at edge N -> call_ack in cycle N+1.
- busy = (state != IDLE). Requests during busy are ignored, not queued; they remain asserted by the requester.
- Pointer arithmetic is modulo 2^DEPTH_LOG2. depth saturates at 0 and at 2^DEPTH_LOG2 and never wraps.
- overflow and underflow clear only on reset.
- Reset asserted mid-pop aborts the pop: ret_valid is not issued, and all state returns to reset values on that edge.
- The RAM write enable is qualified by IDLE, so a write never coincides with a pop read.

Optional Feature:
- Macro FRAME_DEPTH_HWM_EN.
- Defined: depth_hwm is a register that updates to depth whenever depth exceeds it. It resets to 0.
- Undefined: depth_hwm is tied to 0 and no register is inferred. All other behaviour is identical.

Decomposition:
- Shared package frame_pkg holds:
  - the state encoding constants (IDLE=0, POP_RD=1, POP_OUT=2)
  - the frame record width constant, FRAME_W = 2*ADDR_WIDTH, with field order {pc, tos}
  - the default parameter constants
- One sub-module: frame_ram. Single write port, synchronous registered read, width FRAME_W, depth 2^DEPTH_LOG2. It replaces two separate stacks with one wide memory.

Test Plan:
- Reset, then CALL pc=0x123 tos=0x045, then RET ret_val=0xA5 -> call_ack one cycle after the request; ret_valid exactly 2 cycles after ret_req with ret_pc=0x123, ret_tos=0x045, ret_data=0xA5; depth back to 0.
- Three CALLs (pc 0x010/0x020/0x030), then three RETs -> pops in LIFO order 0x030, 0x020, 0x010; busy high on each pop's two in-flight cycles.
- 16 CALLs, then a 17th -> depth=16, overflow=1, call_ack still pulses, 17th frame discarded; the next RET returns the 16th frame.
- RET with depth=0 -> underflow=1, ret_valid at N+2 with ret_pc=0, ret_tos=0, depth stays 0.
- call_req and ret_req both high with depth=2 -> RET serviced first and depth becomes 1; the CALL is acked afterwards and depth becomes 2.
- reset asserted in POP_RD -> no ret_valid; the next cycle shows depth=0, flags 0, state IDLE. With FRAME_DEPTH_HWM_EN defined, depth_hwm=5 after 5 CALLs and 2 RETs.
